pc_sequencer: RTL and testbench
===============================

Name: pc_sequencer

Overview:
- Parametrised next-generation program counter for the single-cycle/multi-cycle datapath.
- Replaces the fixed 32-bit, two-way (PC+4 / PC+imm) counter with an N-way next-PC selector: sequential, relative branch, absolute jump, register jump, call and return.
- Adds a stall hold and a circular return-address stack (RAS).
- Sits between the control unit (pcOp, stall) and instruction memory (PC).

Parameters:
- WIDTH, 32, address width in bits; all PC arithmetic is modulo 2^WIDTH.
- STEP, 4, sequential increment in bytes.
- RAS_DEPTH, 4, return-address stack entries; power of two, at least 2.

Ports:
- CLK  input  1  clock; all state updates on the falling edge.
- MasterReset  input  1  synchronous, active-high reset.
- startPC  input  WIDTH  reset/boot address.
- imm  input  WIDTH  signed byte offset for BRANCH.
- jumpTarget  input  WIDTH  absolute target for JUMP and CALL.
- regTarget  input  WIDTH  register-file target for JREG.
- pcOp  input  3  operation select, sampled each edge.
- stall  input  1  hold PC and stack.
- PC  output  WIDTH  current program counter (registered).
- nextPC  output  WIDTH  combinational value PC will take at the next edge.
- rasEmpty  output  1  stack count == 0.
- rasFull  output  1  stack count == RAS_DEPTH.
- rasOverflow  output  1  sticky; set on CALL while full.
- rasUnderflow  output  1  sticky; set on RET while empty.

Behaviour:
- Reset, sampled at the falling edge while MasterReset=1:
  - PC=startPC; stack count=0; top pointer=0; rasOverflow=0; rasUnderflow=0.
  - Stack contents are don't-care.
  - Reset overrides stall and pcOp.
- pcOp encoding and resulting next PC:
  - 0 SEQ: PC+STEP.
  - 1 BRANCH: PC+imm (two's complement, wraps).
  - 2 JUMP: jumpTarget.
  - 3 JREG: regTarget.
  - 4 CALL: jumpTarget; push PC+STEP.
  - 5 RET: pop; next PC = popped value.
  - 6, 7: treated as SEQ.
- Latency:
  - PC updates one falling edge after pcOp is presented.
  - nextPC reflects the current inputs combinationally, with zero latency.
- stall=1 (no reset): PC holds, the stack is untouched, flags hold, nextPC=PC.
- RAS structure: circular buffer with a top pointer and count 0..RAS_DEPTH.
- CALL while full:
  - Entry written at top+1 (overwrites the oldest); count stays RAS_DEPTH.
  - rasOverflow set.
- RET while empty:
  - next PC = PC+STEP; pointer and count unchanged.
  - rasUnderflow set.
- RET while non-empty: next PC = entry[top]; top decrements with wrap; count decrements.
- Sticky flags clear only on reset.
- Wrap-around: PC=2^WIDTH-STEP with SEQ gives PC=0; no flag.
- Reset mid-sequence (for example, between a CALL and its RET): the stack is emptied, and a later RET underflows.

Optional Feature:
- Macro: PC_ALIGN_CHECK_EN.
- When defined:
  - Adds output misaligned (1 bit, registered, sticky, cleared by reset).
  - misaligned is set when an unstalled non-reset update would load a PC whose low log2(STEP) bits are nonzero.
  - The PC is still loaded as computed.
- When undefined: no port and no logic; behaviour is otherwise identical.

Decomposition:
- Shared package pc_pkg holds:
  - the pcOp localparams (PCOP_SEQ, PCOP_BRANCH, PCOP_JUMP, PCOP_JREG, PCOP_CALL, PCOP_RET);
  - the PCOP_W=3 width constant.
- One natural sub-module: ras_stack.
  - Parametrised by WIDTH and RAS_DEPTH.
  - push/pop inputs; top data, empty, full, overflow and underflow outputs.
- pc_sequencer keeps the next-PC mux, the adders and the PC register.

Test Plan:
- Reset: startPC=0x100, MasterReset=1 for 2 edges, then pcOp=SEQ for 3 edges -> PC=0x100, 0x104, 0x108, 0x10C; flags 0.
- Branch/jump:
  - From PC=0x200, BRANCH imm=-8 -> 0x1F8.
  - Then JUMP 0x400 -> 0x400.
  - Then JREG regTarget=0x80 -> 0x80.
- Stall: PC=0x40 with stall=1 for 3 edges and pcOp=JUMP 0x999 -> PC stays 0x40 and nextPC=0x40; release with SEQ -> 0x44.
- Call/return nesting, RAS_DEPTH=4:
  - From PC=0x10, CALL 0x100 then CALL 0x200 -> PC=0x200.
  - RET -> 0x104.
  - RET -> 0x14.
  - Third RET -> 0x18 with rasUnderflow=1.
- Overflow: 5 consecutive CALLs with RAS_DEPTH=4 -> rasFull=1, rasOverflow=1; 4 RETs return the last four return addresses in LIFO order; the 5th RET underflows.
- Wrap plus optional feature:
  - PC=0xFFFFFFFC with SEQ -> 0x0.
  - With PC_ALIGN_CHECK_EN, JUMP 0x102 -> PC=0x102 and misaligned=1, held until reset.

Source files
------------

// File: rtl/pc_pkg.sv
// Shared pcOp encodings for the program-counter sequencer.
package pc_pkg;

   localparam int unsigned PCOP_W = 3;

   localparam logic [PCOP_W-1:0] PCOP_SEQ    = 3'd0;
   localparam logic [PCOP_W-1:0] PCOP_BRANCH = 3'd1;
   localparam logic [PCOP_W-1:0] PCOP_JUMP   = 3'd2;
   localparam logic [PCOP_W-1:0] PCOP_JREG   = 3'd3;
   localparam logic [PCOP_W-1:0] PCOP_CALL   = 3'd4;
   localparam logic [PCOP_W-1:0] PCOP_RET    = 3'd5;

endpackage

// File: rtl/ras_stack.sv
// Circular return-address stack; a push while full overwrites the oldest entry.
module ras_stack #(
   parameter int unsigned WIDTH     = 32,
   parameter int unsigned RAS_DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] push_data,
   output logic [WIDTH-1:0] top_data,
   output logic             empty,
   output logic             full,
   output logic             overflow,
   output logic             underflow
);

   localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
   localparam int unsigned CNT_W = $clog2(RAS_DEPTH + 1);

   logic [WIDTH-1:0] mem [RAS_DEPTH];
   logic [PTR_W-1:0] top;
   logic [CNT_W-1:0] count;

   assign empty    = (count == '0);
   assign full     = (count == CNT_W'(RAS_DEPTH));
   assign top_data = mem[top];

   // Pointer and count; the pointer wraps naturally since depth is a power of two.
   always_ff @(negedge clk) begin
      if (rst) begin
         top       <= '0;
         count     <= '0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else if (push) begin
         top <= top + PTR_W'(1);
         if (full) overflow <= 1'b1;
         else      count    <= count + CNT_W'(1);
      end else if (pop) begin
         if (empty) begin
            underflow <= 1'b1;
         end else begin
            top   <= top - PTR_W'(1);
            count <= count - CNT_W'(1);
         end
      end
   end

   // Entry storage is not reset; contents are meaningless until pushed.
   always_ff @(negedge clk) begin
      if (push && !rst) mem[top + PTR_W'(1)] <= push_data;
   end

endmodule

// File: rtl/pc_sequencer.sv
// N-way program counter with stall hold and return-address stack.
// Optional alignment monitor enabled by defining PC_ALIGN_CHECK_EN.
module pc_sequencer
   import pc_pkg::*;
#(
   parameter int unsigned WIDTH     = 32,
   parameter int unsigned STEP      = 4,
   parameter int unsigned RAS_DEPTH = 4
) (
   input  logic              CLK,
   input  logic              MasterReset,
   input  logic [WIDTH-1:0]  startPC,
   input  logic [WIDTH-1:0]  imm,
   input  logic [WIDTH-1:0]  jumpTarget,
   input  logic [WIDTH-1:0]  regTarget,
   input  logic [PCOP_W-1:0] pcOp,
   input  logic              stall,
   output logic [WIDTH-1:0]  PC,
   output logic [WIDTH-1:0]  nextPC,
   output logic              rasEmpty,
   output logic              rasFull,
   output logic              rasOverflow,
   output logic              rasUnderflow
`ifdef PC_ALIGN_CHECK_EN
   ,
   output logic              misaligned
`endif
);

   localparam logic [WIDTH-1:0] STEP_V     = WIDTH'(STEP);
   localparam logic [WIDTH-1:0] ALIGN_MASK = WIDTH'(STEP - 1);

   logic [WIDTH-1:0] seq_pc;
   logic [WIDTH-1:0] ras_top;
   logic             advance;
   logic             push;
   logic             pop;

   assign seq_pc  = PC + STEP_V;
   assign advance = !MasterReset && !stall;
   assign push    = advance && (pcOp == PCOP_CALL);
   assign pop     = advance && (pcOp == PCOP_RET);

   // Next-PC select; an empty RET falls through to the sequential address.
   always_comb begin
      nextPC = seq_pc;
      if (MasterReset) begin
         nextPC = startPC;
      end else if (stall) begin
         nextPC = PC;
      end else begin
         case (pcOp)
            PCOP_BRANCH: nextPC = PC + imm;
            PCOP_JUMP:   nextPC = jumpTarget;
            PCOP_JREG:   nextPC = regTarget;
            PCOP_CALL:   nextPC = jumpTarget;
            PCOP_RET:    nextPC = rasEmpty ? seq_pc : ras_top;
            default:     nextPC = seq_pc;
         endcase
      end
   end

   always_ff @(negedge CLK) begin
      if (MasterReset) PC <= startPC;
      else if (!stall) PC <= nextPC;
   end

   ras_stack #(
      .WIDTH     (WIDTH),
      .RAS_DEPTH (RAS_DEPTH)
   ) u_ras (
      .clk       (CLK),
      .rst       (MasterReset),
      .push      (push),
      .pop       (pop),
      .push_data (seq_pc),
      .top_data  (ras_top),
      .empty     (rasEmpty),
      .full      (rasFull),
      .overflow  (rasOverflow),
      .underflow (rasUnderflow)
   );

`ifdef PC_ALIGN_CHECK_EN
   // Sticky flag; the misaligned PC is still loaded.
   always_ff @(negedge CLK) begin
      if (MasterReset) misaligned <= 1'b0;
      else if (advance && ((nextPC & ALIGN_MASK) != '0)) misaligned <= 1'b1;
   end
`else
   logic unused_align;
   assign unused_align = ^ALIGN_MASK;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: queue-based reference model plus directed and random stimulus.
module tb_pc_sequencer;
   import pc_pkg::*;

   logic              CLK = 1'b0;
   logic              MasterReset = 1'b0;
   logic [31:0]       startPC = '0, imm = '0, jumpTarget = '0, regTarget = '0;
   logic [PCOP_W-1:0] pcOp = '0;
   logic              stall = 1'b0;
   logic [31:0]       PC, nextPC;
   logic              rasEmpty, rasFull, rasOverflow, rasUnderflow;
`ifdef PC_ALIGN_CHECK_EN
   logic              misaligned;
`endif

   pc_sequencer #(.WIDTH(32), .STEP(4), .RAS_DEPTH(4)) dut (
      .CLK(CLK), .MasterReset(MasterReset), .startPC(startPC), .imm(imm),
      .jumpTarget(jumpTarget), .regTarget(regTarget), .pcOp(pcOp), .stall(stall),
      .PC(PC), .nextPC(nextPC), .rasEmpty(rasEmpty), .rasFull(rasFull),
      .rasOverflow(rasOverflow), .rasUnderflow(rasUnderflow)
`ifdef PC_ALIGN_CHECK_EN
      , .misaligned(misaligned)
`endif
   );

   always #5 CLK = ~CLK;

   int tests = 0;
   int fails = 0;

   // Reference model: return addresses kept as a bounded LIFO queue.
   logic [31:0] m_pc;
   logic [31:0] m_stack[$];
   bit          m_ovf, m_unf, m_mis, m_valid;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] m_next();
      if (MasterReset) return startPC;
      if (stall) return m_pc;
      case (pcOp)
         3'd1:    return m_pc + imm;
         3'd2:    return jumpTarget;
         3'd3:    return regTarget;
         3'd4:    return jumpTarget;
         3'd5:    return (m_stack.size() == 0) ? m_pc + 32'd4 : m_stack[$];
         default: return m_pc + 32'd4;
      endcase
   endfunction

   task automatic m_update();
      logic [31:0] nx;
      if (MasterReset) begin
         m_pc = startPC; m_stack.delete();
         m_ovf = 0; m_unf = 0; m_mis = 0; m_valid = 1;
      end else if (m_valid && !stall) begin
         nx = m_next();
         if (pcOp == 3'd4) begin
            m_stack.push_back(m_pc + 32'd4);
            if (m_stack.size() > 4) begin
               m_ovf = 1;
               void'(m_stack.pop_front());
            end
         end else if (pcOp == 3'd5) begin
            if (m_stack.size() == 0) m_unf = 1;
            else void'(m_stack.pop_back());
         end
         if (nx[1:0] != 2'b00) m_mis = 1;
         m_pc = nx;
      end
   endtask

   task automatic compare_all();
      if (!m_valid) return;
      chk("pc", PC, m_pc);
      chk("nextpc", nextPC, m_next());
      chk("empty", 32'(rasEmpty), 32'(m_stack.size() == 0));
      chk("full", 32'(rasFull), 32'(m_stack.size() == 4));
      chk("overflow", 32'(rasOverflow), 32'(m_ovf));
      chk("underflow", 32'(rasUnderflow), 32'(m_unf));
`ifdef PC_ALIGN_CHECK_EN
      chk("misaligned", 32'(misaligned), 32'(m_mis));
`endif
   endtask

   // One clock: drive on the rising edge, compare, let the DUT update on the falling edge.
   task automatic cyc(input logic [2:0] op, input logic [31:0] im, input logic [31:0] jt,
                      input logic [31:0] rt, input logic st, input logic rs);
      @(posedge CLK);
      pcOp = op; imm = im; jumpTarget = jt; regTarget = rt; stall = st; MasterReset = rs;
      #1;
      compare_all();
      @(negedge CLK);
      m_update();
      #1;
   endtask

   task automatic do_reset(input logic [31:0] sp);
      startPC = sp;
      cyc(PCOP_SEQ, 0, 0, 0, 0, 1);
   endtask

   initial begin
      m_valid = 0;
      // Reset then sequential
      do_reset(32'h100);
      cyc(PCOP_SEQ, 0, 0, 0, 0, 1);
      chk("lit_reset_pc", PC, 32'h100);
      chk("lit_reset_empty", 32'(rasEmpty), 32'd1);
      cyc(PCOP_SEQ, 0, 0, 0, 0, 0); chk("lit_seq1", PC, 32'h104);
      cyc(PCOP_SEQ, 0, 0, 0, 0, 0); chk("lit_seq2", PC, 32'h108);
      cyc(PCOP_SEQ, 0, 0, 0, 0, 0); chk("lit_seq3", PC, 32'h10C);

      // Branch / jump / register jump
      cyc(PCOP_JUMP, 0, 32'h200, 0, 0, 0);
      cyc(PCOP_BRANCH, -32'sd8, 0, 0, 0, 0); chk("lit_branch", PC, 32'h1F8);
      cyc(PCOP_JUMP, 0, 32'h400, 0, 0, 0);   chk("lit_jump", PC, 32'h400);
      cyc(PCOP_JREG, 0, 0, 32'h80, 0, 0);    chk("lit_jreg", PC, 32'h80);

      // Stall
      cyc(PCOP_JUMP, 0, 32'h40, 0, 0, 0);
      for (int i = 0; i < 3; i++) begin
         cyc(PCOP_JUMP, 0, 32'h999, 0, 1, 0);
         chk("lit_stall_pc", PC, 32'h40);
      end
      cyc(PCOP_SEQ, 0, 0, 0, 0, 0); chk("lit_stall_release", PC, 32'h44);

      // Call/return nesting
      do_reset(32'h10);
      cyc(PCOP_CALL, 0, 32'h100, 0, 0, 0);
      cyc(PCOP_CALL, 0, 32'h200, 0, 0, 0); chk("lit_call2", PC, 32'h200);
      cyc(PCOP_RET, 0, 0, 0, 0, 0);        chk("lit_ret1", PC, 32'h104);
      cyc(PCOP_RET, 0, 0, 0, 0, 0);        chk("lit_ret2", PC, 32'h14);
      cyc(PCOP_RET, 0, 0, 0, 0, 0);        chk("lit_ret3", PC, 32'h18);
      chk("lit_underflow", 32'(rasUnderflow), 32'd1);

      // Overflow: five calls into a four-deep stack
      do_reset(32'h1000);
      for (int i = 0; i < 5; i++) cyc(PCOP_CALL, 0, 32'h2000 + 32'(i) * 32'h100, 0, 0, 0);
      chk("lit_full", 32'(rasFull), 32'd1);
      chk("lit_overflow", 32'(rasOverflow), 32'd1);
      cyc(PCOP_RET, 0, 0, 0, 0, 0); chk("lit_ovf_ret1", PC, 32'h2304);
      cyc(PCOP_RET, 0, 0, 0, 0, 0); chk("lit_ovf_ret2", PC, 32'h2204);
      cyc(PCOP_RET, 0, 0, 0, 0, 0); chk("lit_ovf_ret3", PC, 32'h2104);
      cyc(PCOP_RET, 0, 0, 0, 0, 0); chk("lit_ovf_ret4", PC, 32'h2004);
      cyc(PCOP_RET, 0, 0, 0, 0, 0); chk("lit_ovf_ret5", PC, 32'h2008);
      chk("lit_ovf_underflow", 32'(rasUnderflow), 32'd1);

      // Reset between CALL and RET empties the stack
      cyc(PCOP_CALL, 0, 32'h500, 0, 0, 0);
      do_reset(32'h600);
      chk("lit_midreset_unf", 32'(rasUnderflow), 32'd0);
      cyc(PCOP_RET, 0, 0, 0, 0, 0); chk("lit_midreset_ret", PC, 32'h604);

      // Address wrap and alignment monitor
      do_reset(32'hFFFF_FFF8);
      cyc(PCOP_SEQ, 0, 0, 0, 0, 0); chk("lit_prewrap", PC, 32'hFFFF_FFFC);
      cyc(PCOP_SEQ, 0, 0, 0, 0, 0); chk("lit_wrap", PC, 32'h0);
      cyc(PCOP_JUMP, 0, 32'h102, 0, 0, 0); chk("lit_unaligned_pc", PC, 32'h102);
      cyc(PCOP_SEQ, 0, 0, 0, 0, 0);
`ifdef PC_ALIGN_CHECK_EN
      chk("lit_misaligned", 32'(misaligned), 32'd1);
`endif
      do_reset(32'h0);

      // Randomized traffic
      for (int n = 0; n < 600; n++) begin
         logic [2:0]  op;
         logic [31:0] im, jt, rt;
         logic        st, rs;
         op = 3'($urandom_range(0, 7));
         im = 32'($signed(32'($urandom_range(0, 64))) - 32) << 2;
         jt = {$urandom} & (($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFF : 32'hFFFF_FFFC);
         rt = {$urandom} & 32'hFFFF_FFFC;
         st = ($urandom_range(0, 7) == 0);
         rs = ($urandom_range(0, 63) == 0);
         if (rs) startPC = {$urandom} & 32'hFFFF_FFFC;
         cyc(op, im, jt, rt, st, rs);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
